bus_xcvr_sched: RTL and testbench
=================================

# bus_xcvr_sched

Sequencer and round-robin arbiter for a set of ttl_74245 transceivers that each connect one requester onto the shared 16-bit bus. It drives every transceiver's DIR and nOE and grants the bus to one requester at a time. Direction is set before output enable and released before the next owner, with programmable settle and turnaround gaps in clock cycles, so the transceivers' direction and enable propagation delays never cause bus contention.

## Interface
- N_REQ, 4: number of requesters/transceivers (2..8).
- DIR_SETUP, 2: cycles between a DIR change and nOE assertion; must be ≥1.
- HOLD, 1: minimum cycles nOE stays low per grant; must be ≥1.
- TURN, 2: cycles with all nOE high between grants; must be ≥0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  bus request per requester, level, held until done.
- wr  in  N_REQ  per-requester direction: 1 = A→B (requester drives bus), 0 = B→A.
- dir  out  N_REQ  DIR to each transceiver.
- n_oe  out  N_REQ  nOE to each transceiver, active low.
- gnt  out  N_REQ  one-hot grant, 0 when idle.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when an enabled transfer ends.

## Operation
- All outputs are registered. Reset values: n_oe all 1, dir all 0, gnt 0, busy 0, done 0, state IDLE, rr pointer = N_REQ-1, so req[0] wins first.
- States:
  - **IDLE**
    - If any req is high, pick the first set bit searching from pointer+1 mod N_REQ.
    - Latch idx and wr[idx]; set dir[idx]=wr[idx] and gnt[idx]=1; pointer←idx.
    - Load cnt=DIR_SETUP-1 and go to SETUP.
  - **SETUP**
    - If req[idx] drops: abort. Clear gnt, go to TURN. n_oe is never asserted and no done pulse is issued.
    - Otherwise, when cnt=0: n_oe[idx]=0, cnt=HOLD-1, go to XFER. If cnt≠0, decrement.
  - **XFER**
    - cnt decrements to 0 and saturates there.
    - When cnt=0 and req[idx]=0: n_oe[idx]=1, gnt=0, done=1 for one cycle, cnt=TURN-1, go to TURN. If TURN=0, go directly to IDLE.
  - **TURN**
    - All n_oe stay high. When cnt=0, go to IDLE; otherwise decrement.
- Invariants:
  - At most one n_oe bit is low.
  - dir[idx] does not change while n_oe[idx] is low.
  - Non-granted dir bits hold their last value.
  - A wr change during a grant is ignored.
- Counter width: $clog2(max(DIR_SETUP,HOLD,TURN)+1). Parameter violations are caught by an elaboration-time assertion.
- rst asserted in any state immediately forces the reset values (n_oe high asynchronously). The in-flight transfer is dropped without a done pulse.

## Timing
- In IDLE, req is sampled at edge E0. gnt and dir are valid after E0. n_oe falls after edge E0+DIR_SETUP.
- n_oe stays low for max(HOLD, cycles until req drops) cycles.
- req sampled low at edge Ex in XFER (with cnt=0): n_oe rises and done pulses after Ex.
- Earliest next gnt is after edge Ex+TURN+1.
- Per-grant overhead with defaults: 2 setup cycles + 2 turnaround cycles + 1 IDLE arbitration cycle.
- Simultaneous requests resolve by round robin. A requester re-asserting in the same cycle as its done pulse is served after the other pending requesters.

## Structure
- Shared package bus_sched_pkg:
  - sched_state_t enum (IDLE, SETUP, XFER, TURN).
  - Localparam limit MAX_REQ=8.
- Sub-module rr_pick (combinational): inputs req and pointer; outputs valid and a one-hot/index pick. Unit-tested separately.
- Top level: FSM, counter, output registers.

## Test plan
- **Reset and idle:** rst pulse → n_oe=4'b1111, dir=0, gnt=0. No req for 20 cycles → outputs unchanged, done never high.
- **Single write, defaults:** req[2]=1, wr[2]=1 at E0 →
  - dir[2]=1 and gnt=4'b0100 after E0.
  - n_oe=4'b1011 after E0+2.
  - Drop req after 3 cycles of n_oe low → n_oe=4'b1111, done one cycle.
  - Next gnt no earlier than 3 cycles later.
- **Round robin:** req=4'b1111 held, each requester drops req on its grant → grant order 0,1,2,3,0. Check at every cycle that at most one n_oe bit is 0.
- **Abort in SETUP:** req[1] drops one cycle after gnt → n_oe stays 4'b1111, no done, TURN entered, then IDLE.
- **Reset mid-XFER:** rst asserted mid-cycle while n_oe[3]=0 → n_oe[3]=1 without waiting for a clock edge, no done, next grant goes to req[0] first.
- **Parameter sweep:** DIR_SETUP=1, HOLD=4, TURN=0 → 1-cycle dir→n_oe gap. n_oe stays low 4 cycles even if req drops immediately. Back-to-back grants one IDLE cycle apart.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and limits for the transceiver bus scheduler.
package bus_sched_pkg;

    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StXfer,
        StTurn
    } sched_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_xcvr_sched_rr_pick.sv
// Combinational round-robin picker: first set request after the pointer, wrapping.
module rr_pick import bus_sched_pkg::*; #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xcvr_sched.sv
// Sequences DIR/nOE of per-requester 74245 transceivers and grants a shared bus
// round-robin, with settle and turnaround gaps to avoid contention.
module bus_xcvr_sched import bus_sched_pkg::*; #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DIR_SETUP = 2,
    parameter int unsigned HOLD      = 1,
    parameter int unsigned TURN      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] wr,
    output logic [N_REQ-1:0] dir,
    output logic [N_REQ-1:0] n_oe,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(max3(DIR_SETUP, HOLD, TURN) + 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
    localparam logic [CW-1:0] TURN_LD  = (TURN == 0) ? '0 : CW'(TURN - 1);
    localparam sched_state_t  REL_ST   = (TURN == 0) ? StIdle : StTurn;

    if (N_REQ < 2 || N_REQ > MAX_REQ || DIR_SETUP < 1 || HOLD < 1) begin : g_param_err
        $error("bus_xcvr_sched: illegal parameter combination");
    end

    sched_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] dir_q, dir_d;
    logic [N_REQ-1:0] n_oe_q, n_oe_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic             pick_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        n_oe_d  = n_oe_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // wr is captured only here, so later wr changes cannot move dir mid-grant
                if (pick_valid) begin
                    idx_d           = pick_idx;
                    ptr_d           = pick_idx;
                    dir_d[pick_idx] = wr[pick_idx];
                    gnt_d           = pick_onehot;
                    cnt_d           = SETUP_LD;
                    state_d         = StSetup;
                end
            end
            StSetup: begin
                if (!req[idx_q]) begin
                    gnt_d   = '0;
                    cnt_d   = TURN_LD;
                    state_d = REL_ST;
                end else if (cnt_q == '0) begin
                    n_oe_d[idx_q] = 1'b0;
                    cnt_d         = HOLD_LD;
                    state_d       = StXfer;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StXfer: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!req[idx_q]) begin
                    n_oe_d  = '1;
                    gnt_d   = '0;
                    done_d  = 1'b1;
                    cnt_d   = TURN_LD;
                    state_d = REL_ST;
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            dir_q   <= '0;
            n_oe_q  <= '1;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            n_oe_q  <= n_oe_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign dir  = dir_q;
    assign n_oe = n_oe_q;
    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_bus_xcvr_sched.sv
// Bench: two scheduler configurations on shared stimulus, checked against a grant-age model.
module tb_bus_xcvr_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, wr;
    logic [N-1:0] dir_a, n_oe_a, gnt_a, dir_b, n_oe_b, gnt_b;
    logic         busy_a, done_a, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_xcvr_sched #(.N_REQ(4), .DIR_SETUP(2), .HOLD(1), .TURN(2)) dut_a (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .dir(dir_a), .n_oe(n_oe_a),
        .gnt(gnt_a), .busy(busy_a), .done(done_a)
    );

    bus_xcvr_sched #(.N_REQ(4), .DIR_SETUP(1), .HOLD(4), .TURN(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .dir(dir_b), .n_oe(n_oe_b),
        .gnt(gnt_b), .busy(busy_b), .done(done_b)
    );

    // Model: a grant is described by its owner and its age in edges since arbitration.
    int           ds[2] = '{2, 1};
    int           hd[2] = '{1, 4};
    int           tn[2] = '{2, 0};
    int           owner[2], age[2], quiet[2], last[2];
    logic [N-1:0] m_dir[2], m_noe[2], m_gnt[2];
    logic         m_done[2];
    int           rr_exp[5] = '{0, 1, 2, 3, 0};

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; age[m] = 0; quiet[m] = 0; last[m] = N - 1;
            m_dir[m] = '0; m_noe[m] = '1; m_gnt[m] = '0; m_done[m] = 1'b0;
        end
    endtask

    task automatic end_grant(input int m, input logic with_done);
        m_noe[m] = '1; m_gnt[m] = '0; m_done[m] = with_done;
        quiet[m] = tn[m]; owner[m] = -1;
    endtask

    task automatic model_step(input int m);
        m_done[m] = 1'b0;
        if (owner[m] < 0) begin
            if (quiet[m] > 0) begin
                quiet[m]--;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last[m] + k) % N;
                    if (owner[m] < 0 && req[c]) begin
                        owner[m] = c; age[m] = 0; last[m] = c;
                        m_dir[m][c] = wr[c];
                        m_gnt[m] = 4'b0001 << c;
                    end
                end
            end
        end else begin
            age[m]++;
            if (age[m] <= ds[m]) begin
                if (!req[owner[m]]) end_grant(m, 1'b0);
                else if (age[m] == ds[m]) m_noe[m][owner[m]] = 1'b0;
            end else if (age[m] >= ds[m] + hd[m] && !req[owner[m]]) begin
                end_grant(m, 1'b1);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("a_dir", dir_a, m_dir[0]);
            check("a_n_oe", n_oe_a, m_noe[0]);
            check("a_gnt", gnt_a, m_gnt[0]);
            check("a_done", done_a, m_done[0]);
            check("a_busy", busy_a, (owner[0] >= 0 || quiet[0] > 0));
            check("a_one_noe", ($countones(~n_oe_a) <= 1), 1);
            check("b_dir", dir_b, m_dir[1]);
            check("b_n_oe", n_oe_b, m_noe[1]);
            check("b_gnt", gnt_b, m_gnt[1]);
            check("b_done", done_b, m_done[1]);
            check("b_busy", busy_b, (owner[1] >= 0 || quiet[1] > 0));
            check("b_one_noe", ($countones(~n_oe_b) <= 1), 1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; wr = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < 200), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n, low, dones;
        rst = 1'b1; req = '0; wr = '0;
        repeat (2) @(negedge clk);
        check("rst_noe", n_oe_a, 4'b1111);
        check("rst_dir", dir_a, 4'b0000);
        check("rst_gnt", gnt_a, 4'b0000);
        check("rst_busy", busy_a, 0);
        rst = 1'b0;

        // Idle: nothing moves for 20 cycles
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a || done_b) dones++;
        end
        check("idle_done", dones, 0);
        check("idle_noe", n_oe_a, 4'b1111);

        // Single write with default timing
        do_reset();
        req = 4'b0100; wr = 4'b0100;
        @(negedge clk);
        check("sw_gnt", gnt_a, 4'b0100);
        check("sw_dir2", dir_a[2], 1);
        check("sw_noe_e0", n_oe_a, 4'b1111);
        @(negedge clk);
        check("sw_noe_e1", n_oe_a, 4'b1111);
        @(negedge clk);
        check("sw_noe_low", n_oe_a, 4'b1011);
        repeat (2) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("sw_noe_rel", n_oe_a, 4'b1111);
        check("sw_done", done_a, 1);
        check("sw_gnt_rel", gnt_a, 4'b0000);
        req = 4'b0001; wr = '0;
        @(negedge clk);
        check("sw_done_pulse", done_a, 0);
        n = 1;
        while (gnt_a == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sw_next_gnt_gap", n, 3);
        req = '0;
        wait_idle();

        // Round robin with all requesters pending
        do_reset();
        req = 4'b1111; wr = 4'b1010;
        for (int g = 0; g < 5; g++) begin
            int idx;
            n = 0;
            while (gnt_a == '0 && n < 50) begin @(negedge clk); n++; end
            check("rr_gnt_wait", (n < 50), 1);
            idx = 0;
            for (int b = 0; b < N; b++) if (gnt_a[b]) idx = b;
            check("rr_order", idx, rr_exp[g]);
            n = 0;
            while (n_oe_a[idx] && n < 50) begin @(negedge clk); n++; end
            check("rr_noe_wait", (n < 50), 1);
            req[idx] = 1'b0;
            n = 0;
            while (gnt_a != '0 && n < 50) begin @(negedge clk); n++; end
            check("rr_rel_wait", (n < 50), 1);
            req[idx] = 1'b1;
        end
        req = '0;
        wait_idle();

        // Abort during SETUP
        do_reset();
        req = 4'b0010; wr = '0;
        @(negedge clk);
        check("ab_gnt", gnt_a, 4'b0010);
        req = '0;
        @(negedge clk);
        check("ab_gnt_clr", gnt_a, 4'b0000);
        check("ab_busy1", busy_a, 1);
        check("ab_noe1", n_oe_a, 4'b1111);
        check("ab_done1", done_a, 0);
        @(negedge clk);
        check("ab_busy2", busy_a, 1);
        check("ab_done2", done_a, 0);
        @(negedge clk);
        check("ab_busy3", busy_a, 0);
        check("ab_noe3", n_oe_a, 4'b1111);
        wait_idle();

        // Asynchronous reset while requester 3 drives the bus
        do_reset();
        req = 4'b1000; wr = 4'b1000;
        n = 0;
        while (n_oe_a[3] && n < 20) begin @(negedge clk); n++; end
        check("mr_noe_low", n_oe_a, 4'b0111);
        #2 rst = 1'b1;
        #1;
        check("mr_noe_async", n_oe_a, 4'b1111);
        check("mr_gnt_async", gnt_a, 4'b0000);
        check("mr_done", done_a, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        check("mr_next_gnt", gnt_a, 4'b0001);
        req = '0;
        wait_idle();

        // Short setup, long hold, no turnaround
        do_reset();
        req = 4'b0001; wr = 4'b0001;
        @(negedge clk);
        check("ps_gnt", gnt_b, 4'b0001);
        check("ps_noe_e0", n_oe_b, 4'b1111);
        @(negedge clk);
        check("ps_noe_e1", n_oe_b, 4'b1110);
        req = '0;
        low = 1;
        repeat (6) begin
            @(negedge clk);
            if (!n_oe_b[0]) low++;
        end
        check("ps_hold_len", low, 4);
        wait_idle();

        do_reset();
        req = 4'b0011; wr = 4'b0011;
        n = 0;
        while (n_oe_b[0] && n < 20) begin @(negedge clk); n++; end
        req[0] = 1'b0;
        n = 0;
        while (!done_b && n < 20) begin @(negedge clk); n++; end
        check("ps_done_seen", done_b, 1);
        check("ps_gnt_gap", gnt_b, 4'b0000);
        @(negedge clk);
        check("ps_b2b_gnt", gnt_b, 4'b0010);
        req = '0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
